// File: rtl/vending_core.sv
// vending_core: product select, coin collection, timed dispense and refund controller.
// Defining VEND_TIMEOUT_EN adds an inactivity timeout that forces a refund from COLLECT.
module vending_core #(
    parameter int N_PROD   = 5,
    parameter int VAL_W    = 8,
    parameter int HOLD_CYC = 5000000,
    parameter int TMO_CYC  = 50000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_PROD-1:0]       p_in,
    input  logic                    sel_vld,
    input  logic [N_PROD*VAL_W-1:0] price_tbl,
    input  logic [2:0]              d_in,
    input  logic                    coin_vld,
    input  logic                    cancel,
    output logic                    pr_out,
    output logic [3:0]              pr_id,
    output logic [VAL_W-1:0]        price,
    output logic [VAL_W-1:0]        credit,
    output logic [VAL_W-1:0]        d_change,
    output logic                    chg_vld,
    output logic                    coin_rej,
    output logic                    busy
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_REFUND} state_t;

    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    state_t              r_state;
    logic [3:0]          r_pr_id;
    logic [VAL_W-1:0]    r_price;
    logic [VAL_W-1:0]    r_credit;
    logic [VAL_W-1:0]    r_sel_price;
    logic [VAL_W-1:0]    r_change;
    logic                r_chg_vld;
    logic                r_coin_rej;
    logic                r_pr_out;
    logic                r_busy;
    logic [HOLD_W-1:0]   r_hold;

    logic                w_sel_onehot;
    logic [3:0]          w_sel_idx;
    logic [VAL_W-1:0]    w_sel_price;
    logic [VAL_W-1:0]    w_coin_val;
    logic                w_coin_ok;
    logic [VAL_W:0]      w_credit_sum;
    logic                w_coin_acc;
    logic [VAL_W-1:0]    w_credit_nxt;
    logic [VAL_W-1:0]    w_price_nxt;
    logic                w_tmo_hit;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_sel_idx   = '0;
        w_sel_price = '0;
        for (int k = 0; k < N_PROD; k++) begin
            if (p_in[k]) begin
                w_sel_idx   = 4'(k);
                w_sel_price = price_tbl[k*VAL_W +: VAL_W];
            end
        end
    end

    assign w_sel_onehot = (p_in != '0) && ((p_in & (p_in - N_PROD'(1))) == '0);

    always_comb begin
        w_coin_val = '0;
        w_coin_ok  = 1'b1;
        case (d_in)
            3'b001:  w_coin_val = VAL_W'(25);
            3'b010:  w_coin_val = VAL_W'(50);
            3'b100:  w_coin_val = VAL_W'(75);
            default: w_coin_ok  = 1'b0;
        endcase
    end

    // The extra sum bit flags a credit that would overflow VAL_W; such coins are rejected.
    assign w_credit_sum = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_coin_acc   = coin_vld && w_coin_ok && !w_credit_sum[VAL_W];
    assign w_credit_nxt = w_coin_acc ? w_credit_sum[VAL_W-1:0] : r_credit;
    assign w_price_nxt  = !w_coin_acc              ? r_price :
                          (r_price > w_coin_val)   ? r_price - w_coin_val : '0;

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] r_tmo;

    assign w_tmo_hit = (r_tmo == TMO_W'(TMO_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo <= '0;
        end else if (r_state != S_COLLECT || w_coin_acc) begin
            r_tmo <= '0;
        end else if (!w_tmo_hit) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end
`else
    // Constant false: the timer is compiled out, TMO_CYC stays referenced.
    assign w_tmo_hit = (TMO_CYC < 0);
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pr_id     <= '0;
            r_price     <= '0;
            r_credit    <= '0;
            r_sel_price <= '0;
            r_change    <= '0;
            r_chg_vld   <= 1'b0;
            r_coin_rej  <= 1'b0;
            r_pr_out    <= 1'b0;
            r_busy      <= 1'b0;
            r_hold      <= '0;
        end else begin
            r_chg_vld  <= 1'b0;
            r_coin_rej <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sel_vld && w_sel_onehot) begin
                        r_pr_id     <= w_sel_idx;
                        r_sel_price <= w_sel_price;
                        r_price     <= w_sel_price;
                        r_credit    <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (cancel || (w_tmo_hit && !w_coin_acc && r_price != '0)) begin
                        r_coin_rej <= coin_vld;
                        r_change   <= r_credit;
                        r_chg_vld  <= (r_credit != '0);
                        r_state    <= S_REFUND;
                    end else begin
                        r_coin_rej <= coin_vld && !w_coin_acc;
                        r_credit   <= w_credit_nxt;
                        r_price    <= w_price_nxt;
                        if (w_price_nxt == '0) begin
                            r_change  <= w_credit_nxt - r_sel_price;
                            r_chg_vld <= (w_credit_nxt != r_sel_price);
                            r_pr_out  <= 1'b1;
                            r_hold    <= '0;
                            r_state   <= S_DISPENSE;
                        end
                    end
                end
                S_DISPENSE: begin
                    r_coin_rej <= coin_vld;
                    if (r_hold == HOLD_W'(HOLD_CYC - 1)) begin
                        r_pr_out <= 1'b0;
                        r_price  <= '0;
                        r_credit <= '0;
                        r_change <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                S_REFUND: begin
                    r_coin_rej <= coin_vld;
                    r_credit   <= '0;
                    r_price    <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pr_out   = r_pr_out;
    assign pr_id    = r_pr_id;
    assign price    = r_price;
    assign credit   = r_credit;
    assign d_change = r_change;
    assign chg_vld  = r_chg_vld;
    assign coin_rej = r_coin_rej;
    assign busy     = r_busy;

endmodule

// File: doc/vending_core.md
VENDING_CORE -- requirements
Module: vending_core

Interface
REQ-001 Parameter N_PROD, default 5: number of selectable products (2..16).
REQ-002 Parameter VAL_W, default 8: width of price, credit and change values, in cents.
REQ-003 Parameter HOLD_CYC, default 5000000: number of cycles pr_out is held high in DISPENSE.
REQ-004 Parameter TMO_CYC, default 50000000: inactivity limit in COLLECT (used only with VEND_TIMEOUT_EN).
REQ-005 clk  in  1: single clock; all logic is on the rising edge.
REQ-006 rst  in  1: reset, asynchronous and active-low.
REQ-007 p_in  in  N_PROD: one-hot product select, sampled when sel_vld=1.
REQ-008 sel_vld  in  1: single-cycle select strobe.
REQ-009 price_tbl  in  N_PROD*VAL_W: price of product k at bits [k*VAL_W +: VAL_W]; quasi-static.
REQ-010 d_in  in  3: one-hot coin code (001=25, 010=50, 100=75), sampled when coin_vld=1.
REQ-011 coin_vld  in  1: single-cycle coin strobe.
REQ-012 cancel  in  1: single-cycle refund request.
REQ-013 pr_out  out  1: dispense active.
REQ-014 pr_id  out  4: index of the selected product.
REQ-015 price  out  VAL_W: remaining amount due.
REQ-016 credit  out  VAL_W: accumulated credit.
REQ-017 d_change  out  VAL_W: change or refund amount; valid while chg_vld=1.
REQ-018 chg_vld  out  1: one-cycle change/refund strobe.
REQ-019 coin_rej  out  1: one-cycle strobe marking a rejected coin.
REQ-020 busy  out  1: high in any state other than IDLE.

Function
REQ-021 States: IDLE, COLLECT, DISPENSE, REFUND; the FSM holds one state per cycle.
REQ-022 IDLE with sel_vld=1 and p_in exactly one-hot: latch the index into pr_id, load price from the table, clear credit, go to COLLECT next cycle.
REQ-023 IDLE with a non-one-hot or zero p_in: ignore the strobe and stay in IDLE.
REQ-024 IDLE: ignore coin_vld and cancel.
REQ-025 COLLECT coin_vld with valid one-hot d_in: credit += coin value and price = max(price - coin, 0), both updated the same cycle.
REQ-026 COLLECT coin_vld with invalid d_in, or credit+coin > 2^VAL_W-1: pulse coin_rej; leave credit unchanged.
REQ-027 COLLECT: when the post-update price is 0, go to DISPENSE next cycle.
REQ-028 COLLECT: on entry to DISPENSE, d_change = credit - selected price and chg_vld pulses if d_change != 0.
REQ-029 COLLECT cancel=1: go to REFUND; cancel takes priority over a coin in the same cycle, and that coin is rejected with a coin_rej pulse.
REQ-030 DISPENSE: pr_out=1 for exactly HOLD_CYC cycles, then go to IDLE with price, credit and d_change cleared.
REQ-031 DISPENSE: ignore coin_vld (pulse coin_rej), cancel and sel_vld.
REQ-032 REFUND (one cycle): d_change = credit, chg_vld=1 if credit != 0, then go to IDLE with credit cleared.
REQ-033 Price 0 in the table: COLLECT exits to DISPENSE on the first cycle with no change.
REQ-034 All arithmetic is unsigned VAL_W-bit; no wrap-around is permitted.

Reset
REQ-035 rst=0 asynchronously forces IDLE and clears all counters and all outputs to 0, including pr_id.
REQ-036 rst asserted mid-COLLECT discards credit with no refund strobe.
REQ-037 The first transition after rst deasserts occurs no earlier than the first rising edge of clk.

Configuration
REQ-038 Macro VEND_TIMEOUT_EN defined: in COLLECT, a counter is cleared by each accepted coin; reaching TMO_CYC cycles with no accepted coin forces REFUND.
REQ-039 VEND_TIMEOUT_EN undefined: no timeout counter exists and COLLECT waits indefinitely.

Verification
REQ-040 Defaults; select product 1 at price 25; coin 25 -> DISPENSE next cycle, pr_out high for HOLD_CYC cycles, no chg_vld.
REQ-041 Select product at price 35; coins 25 then 25 -> credit=50, chg_vld pulse with d_change=15, pr_out asserted.
REQ-042 Select product at price 85; coin 50, then cancel -> REFUND, chg_vld with d_change=50, back to IDLE.
REQ-043 Credit at 250 (VAL_W=8); coin 75 -> coin_rej pulse, credit stays 250.
REQ-044 Same-cycle cancel and coin 25 with credit 50 -> coin_rej, refund of 50.
REQ-045 VEND_TIMEOUT_EN defined, TMO_CYC=100; one coin, then idle for 100 cycles -> REFUND with d_change=25; rst=0 mid-COLLECT -> all outputs 0 immediately.
